core2float_vec: RTL and testbench
=================================

Name: core2float_vec

Overview:
- MMIO slave on the Aquila device bus that feeds a floating-point fused-multiply-add operator (result = a*b + c) from on-chip operand vectors.
- Replaces single-pair feeding with DEPTH-entry A/B operand buffers, a result buffer, a start/length command and two modes:
  - element-wise (R[i] = A[i]*B[i]);
  - accumulate (dot product).
- Sits between the core's device port and the FP operator wrapper.

Parameters:
- XLEN, 32, data width of bus and operands.
- DEPTH, 256, entries per A/B/R buffer; power of two, at least 4; AW = clog2(DEPTH).
- MAX_OUT, 8, maximum in-flight operations in element-wise mode; 1 to 15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- strobe_i  in  1  bus request, one-cycle pulse.
- dev_addr_i  in  XLEN  byte address; word index w = dev_addr_i[AW+3:2].
- rw_i  in  1  1 = write, 0 = read.
- byte_enable_i  in  XLEN/8  byte lanes for writes.
- data_i  in  XLEN  write data.
- data_ready_o  out  1  one-cycle acknowledge.
- data_o  out  XLEN  read data.
- op_valid_o  out  1  operand triple valid.
- op_ready_i  in  1  operator accepts the triple.
- op_a_o  out  XLEN  multiplicand.
- op_b_o  out  XLEN  multiplier.
- op_c_o  out  XLEN  addend.
- res_valid_i  in  1  result valid, one-cycle pulse; results return in issue order.
- res_data_i  in  XLEN  result.
- busy_o  out  1  FSM not in IDLE/DONE.
- irq_o  out  1  level, set on completion, cleared by a STATUS read.

Behaviour:
- Reset: the asynchronous reset, active-high, clears all outputs, state, counters, LEN, MODE, ERR and ACC to 0, and sets the FSM to IDLE. Buffer contents are undefined after reset.
- Address regions, selected by w[AW+1:AW]:
  - region 0 = registers, indexed by w[1:0]:
    - 0 CTRL, write: bit0 start, bit1 mode (0 = element-wise, 1 = accumulate).
    - 1 LEN: read/write, 0..DEPTH; written values are saturated to DEPTH.
    - 2 STATUS, read: bit0 busy, bit1 done, bit2 err, bits[7:4] outstanding count.
    - 3 ACC/CYCLES: reads ACC (see Optional Feature).
  - region 1 = A buffer, read/write.
  - region 2 = B buffer, read/write.
  - region 3 = R buffer, read-only; writes are acknowledged and ignored.
- Bus:
  - Every strobe gets data_ready_o exactly one cycle later; for reads, data_o is valid in that same cycle.
  - Buffer writes merge per byte lane by byte_enable_i. Register writes use the full word.
  - While busy, writes to A/B/LEN/CTRL are ignored, acknowledged, and set ERR.
- FSM: IDLE -> ISSUE -> DRAIN -> DONE; DONE -> ISSUE on a new start.
  - start with LEN = 0 goes directly to DONE in 1 cycle.
  - ISSUE:
    - index i counts 0..LEN-1.
    - op_valid_o is held high with stable operands until op_ready_i is sampled high.
    - Element-wise: op_c_o = 0. Issue only while outstanding < MAX_OUT.
    - Accumulate: op_c_o = ACC, where ACC is 0 at start. Issue only when outstanding = 0, i.e. serialised.
  - The issue that transfers i = LEN-1 moves to DRAIN.
  - DRAIN: waits for outstanding = 0, then moves to DONE with irq_o = 1.
- Results:
  - Result k is written to R[k].
  - In accumulate mode, each result also loads ACC. R[LEN-1] equals the final dot product.
- Outstanding counter: +1 on accepted issue, -1 on res_valid_i; both in the same cycle leave it unchanged. A res_valid_i with outstanding = 0 is dropped and sets ERR.
- Bus reads of R while busy return the current contents.
- Pipeline: one issue per cycle is possible in element-wise mode when op_ready_i is held high.
- Reset asserted mid-operation aborts immediately. Results arriving after reset release are dropped and set ERR.

Optional Feature:
- Macro: CORE2FLOAT_CYCLE_CNT_EN.
- When defined: a 32-bit counter clears on start, increments on every busy cycle, and freezes in DONE. Register 3 reads the counter when CTRL bit1 = 0 (element-wise) and ACC when CTRL bit1 = 1.
- When undefined: no counter is built and register 3 always reads ACC.

Test Plan:
- Write A[0..3] = {1.0,2.0,3.0,4.0} and B[0..3] = all 2.0 (0x40000000); set LEN = 4; CTRL = 0x1; operator model has 3-cycle latency -> R = {2.0,4.0,6.0,8.0}, irq_o = 1, STATUS.done = 1.
- Same A/B, CTRL = 0x3 (accumulate) -> ACC = 0x41a00000 (20.0); op_valid_o never asserted while outstanding != 0.
- Element-wise, LEN = 16, operator latency 20, op_ready_i high -> outstanding peaks at MAX_OUT = 8, never 9; all 16 results land in R in order.
- op_ready_i low for 5 cycles mid-stream -> op_a_o/op_b_o/op_c_o held stable; no index skipped.
- Write byte_enable_i = 4'b0100, data 0x00AB0000 to A[2] holding 0x11223344 -> reads 0x11AB3344. A write to LEN while busy -> ignored, STATUS.err = 1.
- LEN = 0 then start -> DONE next cycle, no op_valid_o. Assert rst_i mid-ISSUE -> busy_o = 0 and op_valid_o = 0 immediately (asynchronous).

Source files
------------

// File: rtl/core2float_vec.sv
// core2float_vec: MMIO front-end that streams A/B operand buffers into an FMA operator and collects results in R.
// Build macro CORE2FLOAT_CYCLE_CNT_EN adds a busy-cycle counter readable at register 3 in element-wise mode.
module core2float_vec #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned MAX_OUT = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              strobe_i,
  input  logic [XLEN-1:0]   dev_addr_i,
  input  logic              rw_i,
  input  logic [XLEN/8-1:0] byte_enable_i,
  input  logic [XLEN-1:0]   data_i,
  output logic              data_ready_o,
  output logic [XLEN-1:0]   data_o,
  output logic              op_valid_o,
  input  logic              op_ready_i,
  output logic [XLEN-1:0]   op_a_o,
  output logic [XLEN-1:0]   op_b_o,
  output logic [XLEN-1:0]   op_c_o,
  input  logic              res_valid_i,
  input  logic [XLEN-1:0]   res_data_i,
  output logic              busy_o,
  output logic              irq_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned OW = 4;
  localparam int unsigned BW = XLEN / 8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] a_mem [DEPTH];
  logic [XLEN-1:0] b_mem [DEPTH];
  logic [XLEN-1:0] r_mem [DEPTH];

  logic [LW-1:0]   len_q;
  logic            mode_q;
  logic            err_q;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [OW-1:0]   outs_q, outs_d;
  logic [LW-1:0]   ld_idx_q;
  logic [LW-1:0]   iss_cnt_q;
  logic [AW-1:0]   res_idx_q;
  logic [XLEN-1:0] reg3;
  logic [XLEN-1:0] rd_data;

  logic            fire, res_ok, cap_ok, load_op, irq_set;
  logic            wr, rd, wr_ctrl, wr_len, wr_a, wr_b, wr_blocked, start_go, rd_status;
  logic [1:0]      region;
  logic [1:0]      ridx;
  logic [AW-1:0]   bidx;
  logic [LW-1:0]   len_wr;
  logic            unused_addr;

  // Bus address decode
  assign region      = dev_addr_i[AW+3:AW+2];
  assign ridx        = dev_addr_i[3:2];
  assign bidx        = dev_addr_i[AW+1:2];
  assign unused_addr = ^{dev_addr_i[XLEN-1:AW+4], dev_addr_i[1:0]};

  assign wr         = strobe_i & rw_i;
  assign rd         = strobe_i & ~rw_i;
  assign wr_ctrl    = wr & (region == 2'd0) & (ridx == 2'd0);
  assign wr_len     = wr & (region == 2'd0) & (ridx == 2'd1);
  assign wr_a       = wr & (region == 2'd1) & ~busy_o;
  assign wr_b       = wr & (region == 2'd2) & ~busy_o;
  assign wr_blocked = busy_o & wr & ((region == 2'd1) | (region == 2'd2) | wr_ctrl | wr_len);
  assign start_go   = wr_ctrl & ~busy_o & data_i[0];
  assign rd_status  = rd & (region == 2'd0) & (ridx == 2'd2);
  assign len_wr     = (data_i > XLEN'(DEPTH)) ? LW'(DEPTH) : LW'(data_i);

  // Next-state and issue control
  always_comb begin
    state_d = state_q;
    fire    = op_valid_o & op_ready_i;
    res_ok  = res_valid_i & (outs_q != '0);
    outs_d  = outs_q + OW'(fire) - OW'(res_ok);
    acc_d   = (res_ok & mode_q) ? res_data_i : acc_q;
    cap_ok  = mode_q ? (outs_d == '0) : (outs_d < OW'(MAX_OUT));
    load_op = 1'b0;
    irq_set = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_go) state_d = (len_q == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        load_op = (~op_valid_o | fire) & (ld_idx_q < len_q) & cap_ok;
        if (fire && (iss_cnt_q == len_q - LW'(1))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (outs_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    irq_set = (state_d == S_DONE) & ((state_q != S_DONE) | start_go);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Control/datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_o       <= 1'b0;
      irq_o        <= 1'b0;
      data_ready_o <= 1'b0;
      data_o       <= '0;
      op_valid_o   <= 1'b0;
      op_a_o       <= '0;
      op_b_o       <= '0;
      op_c_o       <= '0;
      len_q        <= '0;
      mode_q       <= 1'b0;
      err_q        <= 1'b0;
      acc_q        <= '0;
      outs_q       <= '0;
      ld_idx_q     <= '0;
      iss_cnt_q    <= '0;
      res_idx_q    <= '0;
    end else begin
      busy_o       <= (state_d == S_ISSUE) | (state_d == S_DRAIN);
      data_ready_o <= strobe_i;
      outs_q       <= outs_d;
      err_q        <= err_q | wr_blocked | (res_valid_i & ~res_ok);

      if (rd) data_o <= rd_data;

      if (irq_set)        irq_o <= 1'b1;
      else if (rd_status) irq_o <= 1'b0;

      if (wr_len & ~busy_o)  len_q  <= len_wr;
      if (wr_ctrl & ~busy_o) mode_q <= data_i[1];

      if (load_op) begin
        op_valid_o <= 1'b1;
        op_a_o     <= a_mem[ld_idx_q[AW-1:0]];
        op_b_o     <= b_mem[ld_idx_q[AW-1:0]];
        op_c_o     <= mode_q ? acc_d : '0;
        ld_idx_q   <= ld_idx_q + LW'(1);
      end else if (fire) begin
        op_valid_o <= 1'b0;
      end

      if (start_go) begin
        acc_q     <= '0;
        ld_idx_q  <= '0;
        iss_cnt_q <= '0;
        res_idx_q <= '0;
      end else begin
        acc_q <= acc_d;
        if (fire)   iss_cnt_q <= iss_cnt_q + LW'(1);
        if (res_ok) res_idx_q <= res_idx_q + AW'(1);
      end
    end
  end

  // Operand buffers: byte-lane merged writes, ignored while busy
  always_ff @(posedge clk_i) begin
    for (int unsigned j = 0; j < BW; j++) begin
      if (wr_a && byte_enable_i[j]) a_mem[bidx][8*j +: 8] <= data_i[8*j +: 8];
      if (wr_b && byte_enable_i[j]) b_mem[bidx][8*j +: 8] <= data_i[8*j +: 8];
    end
  end

  // Results land in issue order
  always_ff @(posedge clk_i) begin
    if (res_ok) r_mem[res_idx_q] <= res_data_i;
  end

`ifdef CORE2FLOAT_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         cyc_q <= '0;
    else if (start_go) cyc_q <= '0;
    else if (busy_o)   cyc_q <= cyc_q + 32'd1;
  end

  assign reg3 = mode_q ? acc_q : XLEN'(cyc_q);
`else
  assign reg3 = acc_q;
`endif

  // Read mux
  always_comb begin
    rd_data = '0;
    case (region)
      2'd0: begin
        case (ridx)
          2'd0:    rd_data = XLEN'({mode_q, 1'b0});
          2'd1:    rd_data = XLEN'(len_q);
          2'd2:    rd_data = XLEN'({outs_q, 1'b0, err_q, (state_q == S_DONE), busy_o});
          default: rd_data = reg3;
        endcase
      end
      2'd1:    rd_data = a_mem[bidx];
      2'd2:    rd_data = b_mem[bidx];
      default: rd_data = r_mem[bidx];
    endcase
  end

endmodule

// File: tb/tb_core2float_vec.sv
// Directed + randomized bench for core2float_vec with an in-bench FMA operator and real-arithmetic reference.
module tb_core2float_vec;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned MAX_OUT = 8;
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [31:0] REG_CTRL   = 32'h0;
  localparam logic [31:0] REG_LEN    = 32'h4;
  localparam logic [31:0] REG_STATUS = 32'h8;
  localparam logic [31:0] REG_ACC    = 32'hC;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              strobe_i;
  logic [XLEN-1:0]   dev_addr_i;
  logic              rw_i;
  logic [XLEN/8-1:0] byte_enable_i;
  logic [XLEN-1:0]   data_i;
  logic              data_ready_o;
  logic [XLEN-1:0]   data_o;
  logic              op_valid_o;
  logic              op_ready_i;
  logic [XLEN-1:0]   op_a_o, op_b_o, op_c_o;
  logic              res_valid_i;
  logic [XLEN-1:0]   res_data_i;
  logic              busy_o;
  logic              irq_o;

  core2float_vec dut (
    .clk_i(clk_i), .rst_i(rst_i), .strobe_i(strobe_i), .dev_addr_i(dev_addr_i),
    .rw_i(rw_i), .byte_enable_i(byte_enable_i), .data_i(data_i),
    .data_ready_o(data_ready_o), .data_o(data_o),
    .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .op_c_o(op_c_o),
    .res_valid_i(res_valid_i), .res_data_i(res_data_i),
    .busy_o(busy_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Operator-model knobs (written by the main sequence only)
  int lat       = 3;
  bit rand_rdy  = 1'b0;
  bit force_low = 1'b0;
  bit acc_chk   = 1'b0;

  // Operator-model observations (written by the operator process only)
  int inflight = 0;
  int peak     = 0;
  int stab_err = 0;
  int acc_err  = 0;
  int cyc      = 0;

  logic [31:0] va [DEPTH];
  logic [31:0] vb [DEPTH];
  logic        exp_err = 1'b0;

  function automatic real sp2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] rand_fp();
    int  m;
    real r;
    m = int'($urandom_range(0, 15));
    r = real'(m);
    if (m != 0 && $urandom_range(0, 1) == 1) r = -r;
    return r2sp(r);
  endfunction

  function automatic logic [31:0] addr_of(input int region, input int idx);
    return 32'((region << (AW + 2)) | (idx << 2));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  // FMA operator: fixed latency, in-order results, configurable ready behaviour
  initial begin : operator
    logic [31:0] q_res [$];
    int          q_due [$];
    logic        prev_valid, prev_fire, fire;
    logic [95:0] prev_ops;
    prev_valid  = 1'b0;
    prev_fire   = 1'b0;
    prev_ops    = '0;
    op_ready_i  = 1'b0;
    res_valid_i = 1'b0;
    res_data_i  = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_i && prev_valid && !prev_fire &&
          (!op_valid_o || {op_a_o, op_b_o, op_c_o} !== prev_ops)) stab_err++;
      if (!rst_i && op_valid_o && acc_chk && inflight != 0) acc_err++;
      op_ready_i = force_low ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      fire = op_valid_o & op_ready_i & ~rst_i;
      if (fire) begin
        q_res.push_back(r2sp(sp2r(op_a_o) * sp2r(op_b_o) + sp2r(op_c_o)));
        q_due.push_back(cyc + lat);
        inflight++;
      end
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        res_valid_i = 1'b1;
        res_data_i  = q_res.pop_front();
        void'(q_due.pop_front());
        inflight--;
      end else begin
        res_valid_i = 1'b0;
      end
      if (inflight > peak) peak = inflight;
      prev_valid = op_valid_o & ~rst_i;
      prev_fire  = fire;
      prev_ops   = {op_a_o, op_b_o, op_c_o};
    end
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk_i);
    strobe_i = 1'b1; rw_i = 1'b1; dev_addr_i = addr; data_i = data; byte_enable_i = be;
    @(negedge clk_i);
    strobe_i = 1'b0; rw_i = 1'b0;
    check("wr_ack", 32'(data_ready_o), 32'd1);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk_i);
    strobe_i = 1'b1; rw_i = 1'b0; dev_addr_i = addr;
    @(negedge clk_i);
    strobe_i = 1'b0;
    check("rd_ack", 32'(data_ready_o), 32'd1);
    data = data_o;
  endtask

  task automatic wait_irq(input int budget, input string tag);
    int n;
    n = 0;
    while (irq_o !== 1'b1 && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, 32'(irq_o), 32'd1);
  endtask

  task automatic start_vec(input int len, input bit acc, input int latency, input bit rr);
    lat      = latency;
    rand_rdy = rr;
    acc_chk  = acc;
    for (int i = 0; i < len; i++) begin
      bus_write(addr_of(1, i), va[i], 4'hF);
      bus_write(addr_of(2, i), vb[i], 4'hF);
    end
    bus_write(REG_LEN, 32'(len), 4'hF);
    bus_write(REG_CTRL, acc ? 32'h3 : 32'h1, 4'hF);
    check("busy_after_start", 32'(busy_o), 32'd1);
  endtask

  task automatic finish_vec(input int len, input bit acc, input string tag);
    real         sum;
    logic [31:0] got, expv;
    wait_irq(8000, {tag, "_irq"});
    sum = 0.0;
    for (int i = 0; i < len; i++) begin
      if (acc) begin
        sum  = sum + sp2r(va[i]) * sp2r(vb[i]);
        expv = r2sp(sum);
      end else begin
        expv = r2sp(sp2r(va[i]) * sp2r(vb[i]) + 0.0);
      end
      bus_read(addr_of(3, i), got);
      check($sformatf("%s_R[%0d]", tag, i), got, expv);
    end
    bus_read(REG_STATUS, got);
    check({tag, "_status"}, got, {29'd0, exp_err, 2'b10});
    check({tag, "_irq_clr"}, 32'(irq_o), 32'd0);
    acc_chk  = 1'b0;
    rand_rdy = 1'b0;
  endtask

  initial begin : main
    logic [31:0] got, oldv, newv, expv;
    logic [3:0]  be;
    int          len;

    strobe_i = 1'b0; rw_i = 1'b0; dev_addr_i = '0; byte_enable_i = '0; data_i = '0;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_op_valid", 32'(op_valid_o), 32'd0);
    check("rst_data_ready", 32'(data_ready_o), 32'd0);
    bus_read(REG_STATUS, got); check("rst_status", got, 32'd0);
    bus_read(REG_LEN, got);    check("rst_len", got, 32'd0);
    bus_read(REG_ACC, got);    check("rst_acc", got, 32'd0);

    // Element-wise and accumulate on the fixed 4-entry vectors
    va[0] = 32'h3f800000; va[1] = 32'h40000000; va[2] = 32'h40400000; va[3] = 32'h40800000;
    for (int i = 0; i < 4; i++) vb[i] = 32'h40000000;
    start_vec(4, 1'b0, 3, 1'b0);
    finish_vec(4, 1'b0, "ew4");
    start_vec(4, 1'b1, 3, 1'b0);
    finish_vec(4, 1'b1, "acc4");
    bus_read(REG_ACC, got); check("acc4_value", got, 32'h41a00000);

    // Byte-lane merge into A and B
    bus_write(addr_of(1, 2), 32'h11223344, 4'hF);
    bus_write(addr_of(1, 2), 32'h00AB0000, 4'b0100);
    bus_read(addr_of(1, 2), got); check("be_merge_a2", got, 32'h11AB3344);
    oldv = $urandom; newv = $urandom; be = 4'($urandom_range(0, 15));
    bus_write(addr_of(2, 5), oldv, 4'hF);
    bus_write(addr_of(2, 5), newv, be);
    for (int j = 0; j < 4; j++) expv[8*j +: 8] = be[j] ? newv[8*j +: 8] : oldv[8*j +: 8];
    bus_read(addr_of(2, 5), got); check("be_merge_b5", got, expv);

    // Deep pipeline: outstanding must saturate at MAX_OUT
    for (int i = 0; i < 16; i++) begin va[i] = rand_fp(); vb[i] = rand_fp(); end
    start_vec(16, 1'b0, 20, 1'b0);
    finish_vec(16, 1'b0, "ew16");
    check("peak_outstanding", 32'(peak), 32'(MAX_OUT));

    // Operator stall mid-stream
    for (int i = 0; i < 12; i++) begin va[i] = rand_fp(); vb[i] = rand_fp(); end
    start_vec(12, 1'b0, 4, 1'b0);
    repeat (3) @(negedge clk_i);
    force_low = 1'b1;
    repeat (5) @(negedge clk_i);
    force_low = 1'b0;
    finish_vec(12, 1'b0, "stall12");
    check("stall_stable", 32'(stab_err), 32'd0);

    // Random ready, both modes
    len = int'($urandom_range(20, 32));
    for (int i = 0; i < len; i++) begin va[i] = rand_fp(); vb[i] = rand_fp(); end
    start_vec(len, 1'b0, int'($urandom_range(1, 6)), 1'b1);
    finish_vec(len, 1'b0, "ew_rand");
    len = int'($urandom_range(12, 20));
    for (int i = 0; i < len; i++) begin va[i] = rand_fp(); vb[i] = rand_fp(); end
    start_vec(len, 1'b1, int'($urandom_range(2, 5)), 1'b1);
    finish_vec(len, 1'b1, "acc_rand");
    check("acc_serialised", 32'(acc_err), 32'd0);

    // LEN saturation
    bus_write(REG_LEN, 32'd1000, 4'hF);
    bus_read(REG_LEN, got); check("len_sat_1000", got, 32'(DEPTH));
    bus_write(REG_LEN, 32'(DEPTH), 4'hF);
    bus_read(REG_LEN, got); check("len_depth", got, 32'(DEPTH));

    // Writes while busy are ignored and flag ERR
    for (int i = 0; i < 16; i++) begin va[i] = rand_fp(); vb[i] = rand_fp(); end
    start_vec(16, 1'b0, 20, 1'b0);
    bus_write(REG_LEN, 32'd3, 4'hF);
    exp_err = 1'b1;
    finish_vec(16, 1'b0, "busy_wr");
    bus_read(REG_LEN, got); check("len_unchanged", got, 32'd16);

    // LEN = 0 completes immediately without issuing
    bus_write(REG_LEN, 32'd0, 4'hF);
    bus_write(REG_CTRL, 32'h1, 4'hF);
    check("len0_irq", 32'(irq_o), 32'd1);
    check("len0_busy", 32'(busy_o), 32'd0);
    check("len0_op_valid", 32'(op_valid_o), 32'd0);
    bus_read(REG_STATUS, got); check("len0_status", got, 32'h6);

    // Asynchronous reset mid-issue; late results are dropped and flag ERR
    for (int i = 0; i < 16; i++) begin va[i] = rand_fp(); vb[i] = rand_fp(); end
    start_vec(16, 1'b0, 20, 1'b0);
    repeat (4) @(negedge clk_i);
    check("pre_rst_op_valid", 32'(op_valid_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy_o), 32'd0);
    check("async_rst_op_valid", 32'(op_valid_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (40) @(negedge clk_i);
    bus_read(REG_STATUS, got); check("post_rst_status", got, 32'h4);
    bus_read(REG_LEN, got);    check("post_rst_len", got, 32'd0);

    check("final_peak", 32'(peak), 32'(MAX_OUT));
    check("final_stable", 32'(stab_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
